// File: rtl/angle_reduce_if.sv
// Handshake and data bundle between the angle source, the angle reducer and the CORDIC core.
interface angle_reduce_if #(
    parameter int WIDTH = 32
);
    logic                    valid_in;
    logic [31:0]             angle_float;
    logic signed [WIDTH-1:0] angle_fixed;
    logic signed [2:0]       flips;
    logic                    err;
    logic                    busy;
    logic                    valid_out;

    modport master (
        output valid_in, angle_float,
        input  angle_fixed, flips, err, busy, valid_out
    );

    modport slave (
        input  valid_in, angle_float,
        output angle_fixed, flips, err, busy, valid_out
    );
endinterface

// File: rtl/angle_reduce.sv
// Converts an IEEE-754 angle in degrees to fixed point, folded into [-90,+90],
// together with the cosine sign that the fold introduces.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for valid_in; angle_float is captured on leaving
// S_UNPACK | decode float into an unsigned fixed-point magnitude / error
// S_MOD    | restoring modulo 360, one step per cycle, k counts down to 0
// S_WRAP   | apply sign and wrap into [-180,180)
// S_FOLD   | fold into [-90,90]; output registers load on leaving
// S_DONE   | valid_out pulse
module angle_reduce #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int MOD_STEPS = 7
) (
    input  logic          clk,
    input  logic          rst,
    angle_reduce_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MOD,
        S_WRAP,
        S_FOLD,
        S_DONE
    } state_t;

    localparam int KW = (MOD_STEPS > 1) ? $clog2(MOD_STEPS) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(MOD_STEPS - 1);

    localparam logic [WIDTH-1:0]        DEG360 = WIDTH'(360) << FRAC;
    localparam logic signed [WIDTH-1:0] P360   = WIDTH'(360) << FRAC;
    localparam logic signed [WIDTH-1:0] P180   = WIDTH'(180) << FRAC;
    localparam logic signed [WIDTH-1:0] P90    = WIDTH'(90) << FRAC;
    localparam logic signed [WIDTH-1:0] N180   = -P180;
    localparam logic signed [WIDTH-1:0] N90    = -P90;

    state_t state, state_next;

    logic [31:0]             float_q;
    logic [WIDTH-1:0]        mag;
    logic                    sign_q;
    logic                    err_q;
    logic [KW-1:0]           k_cnt;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] ang_q;
    logic signed [2:0]       flips_q;
    logic                    err_out;

    logic [7:0]              exp_f;
    logic [WIDTH+23:0]       mant_ext;
    logic [WIDTH+23:0]       mag_wide;
    int                      shift_amt;
    logic [WIDTH-1:0]        unp_mag;
    logic                    unp_err;

    logic [WIDTH-1:0]        mod_const;
    logic                    mod_ge;

    logic signed [WIDTH-1:0] signed_mag;
    logic signed [WIDTH-1:0] wrap_val;
    logic signed [WIDTH-1:0] fold_val;
    logic                    fold_flip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.valid_in) state_next = S_UNPACK;
            S_UNPACK: state_next = S_MOD;
            S_MOD:    if (k_cnt == '0) state_next = S_WRAP;
            S_WRAP:   state_next = S_FOLD;
            S_FOLD:   state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign exp_f    = float_q[30:23];
    assign mant_ext = {{WIDTH{1'b0}}, 1'b1, float_q[22:0]};
    assign shift_amt = int'(exp_f) - (150 - FRAC);

    // Zero and denormals collapse to magnitude 0 without raising err.
    always_comb begin
        unp_mag  = '0;
        unp_err  = 1'b0;
        mag_wide = '0;
        if (exp_f == 8'hFF) begin
            unp_err = 1'b1;
        end else if (exp_f != 8'h00) begin
            if (int'(exp_f) - 127 >= WIDTH - FRAC - 1) begin
                unp_err = 1'b1;
            end else begin
                if (shift_amt >= 0) begin
                    mag_wide = mant_ext << shift_amt;
                end else begin
                    mag_wide = mant_ext >> (-shift_amt);
                end
                unp_mag = mag_wide[WIDTH-1:0];
            end
        end
    end

    assign mod_const = DEG360 << k_cnt;
    assign mod_ge    = (mag >= mod_const);

    always_comb begin
        signed_mag = sign_q ? -$signed(mag) : $signed(mag);
        wrap_val   = signed_mag;
        if (signed_mag >= P180) begin
            wrap_val = signed_mag - P360;
        end else if (signed_mag < N180) begin
            wrap_val = signed_mag + P360;
        end
    end

    // +90 and -90 are deliberately left unfolded.
    always_comb begin
        fold_val  = acc;
        fold_flip = 1'b0;
        if (acc > P90) begin
            fold_val  = P180 - acc;
            fold_flip = 1'b1;
        end else if (acc < N90) begin
            fold_val  = N180 - acc;
            fold_flip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            float_q <= '0;
            mag     <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            k_cnt   <= '0;
            acc     <= '0;
            ang_q   <= '0;
            flips_q <= 3'sd1;
            err_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid_in) float_q <= bus.angle_float;
                end
                S_UNPACK: begin
                    mag    <= unp_mag;
                    sign_q <= float_q[31];
                    err_q  <= unp_err;
                    k_cnt  <= K_TOP;
                end
                S_MOD: begin
                    if (mod_ge) mag <= mag - mod_const;
                    if (k_cnt != '0) k_cnt <= k_cnt - 1'b1;
                end
                S_WRAP: begin
                    acc <= wrap_val;
                end
                S_FOLD: begin
                    if (err_q) begin
                        ang_q   <= '0;
                        flips_q <= 3'sd1;
                        err_out <= 1'b1;
                    end else begin
                        ang_q   <= fold_val;
                        flips_q <= fold_flip ? -3'sd1 : 3'sd1;
                        err_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.angle_fixed = ang_q;
    assign bus.flips       = flips_q;
    assign bus.err         = err_out;
    assign bus.valid_out   = (state == S_DONE);
    assign bus.busy        = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_angle_reduce.sv
// Bench for angle_reduce: directed cases, control-path cases and random
// floats compared against a real-arithmetic reference model.
module tb_angle_reduce;

    localparam int LATENCY = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    angle_reduce_if #(.WIDTH(32)) bus ();

    angle_reduce #(.WIDTH(32), .FRAC(16), .MOD_STEPS(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: decode to a real value, truncate toward zero into Q16.16, then reduce.
    function automatic void model(input logic [31:0] f, output logic [31:0] ang,
                                  output logic [2:0] fl, output logic er);
        int     e;
        int     p;
        real    x;
        longint mag;
        longint a;
        longint full;
        longint half;
        longint quart;
        full  = 360 * 65536;
        half  = 180 * 65536;
        quart = 90 * 65536;
        e   = int'(f[30:23]);
        ang = '0;
        fl  = 3'b001;
        er  = 1'b0;
        if (e == 255 || (e != 0 && e - 127 >= 15)) begin
            er = 1'b1;
            return;
        end
        if (e == 0) begin
            mag = 0;
        end else begin
            x = real'({1'b1, f[22:0]});
            p = e - 134;
            while (p > 0) begin x = x * 2.0; p--; end
            while (p < 0) begin x = x / 2.0; p++; end
            mag = longint'($floor(x));
        end
        a = mag % full;
        if (f[31]) a = -a;
        if (a >= half) a = a - full;
        else if (a < -half) a = a + full;
        if (a > quart) begin
            a  = half - a;
            fl = 3'b111;
        end else if (a < -quart) begin
            a  = -half - a;
            fl = 3'b111;
        end
        ang = a[31:0];
    endfunction

    task automatic convert(input logic [31:0] f, output int lat);
        int cycles;
        @(negedge clk);
        bus.valid_in    = 1'b1;
        bus.angle_float = f;
        @(negedge clk);
        bus.valid_in = 1'b0;
        chk("busy_after_capture", {63'b0, bus.busy}, 64'd1);
        cycles = 0;
        while (!bus.valid_out && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        lat = bus.valid_out ? cycles : -1;
    endtask

    task automatic run_check(input string tag, input logic [31:0] f, input logic [31:0] ang,
                             input logic [2:0] fl, input logic er);
        int lat;
        convert(f, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        chk({tag, "_angle"}, {32'b0, bus.angle_fixed}, {32'b0, ang});
        chk({tag, "_flips"}, {61'b0, bus.flips}, {61'b0, fl});
        chk({tag, "_err"}, {63'b0, bus.err}, {63'b0, er});
        chk({tag, "_busy_done"}, {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, {63'b0, bus.valid_out}, 64'd0);
    endtask

    typedef struct {
        logic [31:0] f;
        logic [31:0] ang;
        logic [2:0]  fl;
        logic        er;
    } vec_t;

    vec_t dir_vecs[$] = '{
        '{32'h41F00000, 32'h001E0000, 3'b001, 1'b0},
        '{32'h43160000, 32'h001E0000, 3'b111, 1'b0},
        '{32'h43340000, 32'h00000000, 3'b111, 1'b0},
        '{32'hC3480000, 32'h00140000, 3'b111, 1'b0},
        '{32'hC2B40000, 32'hFFA60000, 3'b001, 1'b0},
        '{32'h44342000, 32'h00008000, 3'b001, 1'b0},
        '{32'h00000001, 32'h00000000, 3'b001, 1'b0},
        '{32'h49742400, 32'h00000000, 3'b001, 1'b1},
        '{32'h7FC00000, 32'h00000000, 3'b001, 1'b1},
        '{32'h7F800000, 32'h00000000, 3'b001, 1'b1},
        '{32'h42B40000, 32'h005A0000, 3'b001, 1'b0},
        '{32'hC3340000, 32'h00000000, 3'b111, 1'b0},
        '{32'h47000000, 32'h00000000, 3'b001, 1'b1},
        '{32'h43870000, 32'hFFA60000, 3'b001, 1'b0}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] f;
        logic [31:0] m_ang;
        logic [2:0]  m_fl;
        logic        m_er;
        int          cycles;
        int          extra;
        int          r;

        bus.valid_in    = 1'b0;
        bus.angle_float = '0;
        repeat (3) @(negedge clk);
        chk("reset_angle", {32'b0, bus.angle_fixed}, 64'd0);
        chk("reset_flips", {61'b0, bus.flips}, 64'd1);
        chk("reset_err", {63'b0, bus.err}, 64'd0);
        chk("reset_busy", {63'b0, bus.busy}, 64'd0);
        chk("reset_valid", {63'b0, bus.valid_out}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (dir_vecs[i])
            run_check($sformatf("dir%0d", i), dir_vecs[i].f, dir_vecs[i].ang,
                      dir_vecs[i].fl, dir_vecs[i].er);

        // valid_in while busy and while in DONE must be ignored
        @(negedge clk);
        bus.valid_in    = 1'b1;
        bus.angle_float = 32'h41F00000;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.valid_in    = 1'b1;
        bus.angle_float = 32'h43160000;
        @(negedge clk);
        bus.valid_in = 1'b0;
        cycles = 4;
        while (!bus.valid_out && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        chk("ignore_latency", 64'(cycles), 64'(LATENCY));
        bus.valid_in    = 1'b1;
        bus.angle_float = 32'h43160000;
        @(negedge clk);
        bus.valid_in = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.valid_out) extra++;
        end
        chk("ignore_extra_valid", 64'(extra), 64'd0);
        chk("ignore_angle", {32'b0, bus.angle_fixed}, 64'h001E0000);
        chk("ignore_flips", {61'b0, bus.flips}, 64'd1);

        // reset mid-MOD aborts and clears outputs
        run_check("pre_rst", 32'h43160000, 32'h001E0000, 3'b111, 1'b0);
        @(negedge clk);
        bus.valid_in    = 1'b1;
        bus.angle_float = 32'hC3480000;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_angle", {32'b0, bus.angle_fixed}, 64'd0);
        chk("midrst_flips", {61'b0, bus.flips}, 64'd1);
        chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
        chk("midrst_valid", {63'b0, bus.valid_out}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.valid_out) extra++;
        end
        chk("midrst_no_valid", 64'(extra), 64'd0);
        run_check("post_rst", 32'hC3480000, 32'h00140000, 3'b111, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            f = $urandom;
            case (r)
                0:       f[30:23] = 8'hFF;
                1:       f[30:23] = 8'h00;
                2:       f[30:23] = 8'd142;
                3:       f[30:23] = 8'd141;
                default: f[30:23] = 8'($urandom_range(112, 140));
            endcase
            model(f, m_ang, m_fl, m_er);
            run_check($sformatf("rnd%0d_%08h", i, f), f, m_ang, m_fl, m_er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
